instr_stream_src: RTL and testbench
===================================

INSTR_STREAM_SRC -- requirements
Module: instr_stream_src

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 Parameter NOP_INSTR, default 16'h0000, word driven on instr_out when no instruction is issued.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  host write strobe for one instruction word.
REQ-006 push_data  input  16  instruction word written on push.
REQ-007 clear  input  1  synchronous flush/abort.
REQ-008 run  input  1  host enable for issuing to the CPU.
REQ-009 fetch_en  input  1  CPU ready to take an instruction this cycle.
REQ-010 instr_out  output  16  registered instruction to the CPU's instr_in.
REQ-011 instr_valid  output  1  instr_out holds a popped word this cycle.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 hlt_seen  output  1  a HLT word (opcode 4'hF) has been issued.
REQ-015 issued  output  16  number of words popped since reset/clear.

Function
REQ-016 The block SHALL contain a DEPTH-entry circular FIFO; read/write pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM SHALL have states IDLE, RUN and HALT.
REQ-018 IDLE->RUN on a rising edge with run=1; RUN->IDLE on a rising edge with run=0; no pop occurs on the edge that leaves RUN.
REQ-019 A pop SHALL occur on a rising edge iff state==RUN, run=1, fetch_en=1 and count>0.
REQ-020 On a pop, instr_out SHALL take the head word and instr_valid SHALL be 1 from that edge (latency one cycle from fetch_en sampled).
REQ-021 On any edge without a pop, instr_out SHALL be NOP_INSTR and instr_valid SHALL be 0.
REQ-022 A push with full=0 SHALL store push_data at the tail; a push with full=1 SHALL be dropped with no state change, even if a pop occurs on the same edge.
REQ-023 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-024 Push on an empty FIFO in RUN SHALL not be issued on the same edge; the earliest issue is the next qualifying edge.
REQ-025 If the popped word has bits [15:12]==4'hF, the FSM SHALL enter HALT and hlt_seen SHALL be 1 from the same edge on which the word appears on instr_out.
REQ-026 In HALT no pops SHALL occur regardless of run/fetch_en; pushes remain accepted; only clear or reset leaves HALT.
REQ-027 issued SHALL increment by 1 per pop and wrap 16'hFFFF->16'h0000.
REQ-028 clear=1 SHALL, on the rising edge, empty the FIFO, zero the pointers, count, issued and hlt_seen, drive NOP_INSTR with instr_valid=0, and enter IDLE; clear overrides push and pop on the same edge.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state IDLE, empty the FIFO, and set instr_out=NOP_INSTR, instr_valid=0, full=0, count=0, hlt_seen=0, issued=0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered words; after release, the first pushed word is the first issued.

Verification
REQ-031 Push B102,A100,F000; run=1, fetch_en=1 -> instr_out B102, A100, F000 on three consecutive edges with instr_valid=1; hlt_seen=1 with F000; then NOP_INSTR, instr_valid=0; issued=3.
REQ-032 Push 17 words with run=0 -> full=1 and count=16 after the 16th; the 17th is dropped; issuing returns exactly words 1..16 in order.
REQ-033 In RUN, fetch_en toggling 1,0,1 with 2 words buffered -> valid, NOP/invalid, valid; order preserved.
REQ-034 After HALT, push 0462 and pulse fetch_en -> nothing issued; pulse clear, then run -> count=0, issued=0, hlt_seen=0, nothing issued.
REQ-035 Push 3 words, issue 1, assert rst_n=0 between edges -> outputs reset immediately; after release, push 1462 -> 1462 is the first word issued.
REQ-036 Fill/drain 40 words through a 16-deep FIFO with concurrent push and pop -> pointer wrap is correct, count stays consistent, and issued=40.

Source files
------------

// File: rtl/instr_stream_src_if.sv
// Host/CPU-side signal bundle for instr_stream_src.
// master drives host and CPU controls; slave is the stream source itself.
interface instr_stream_src_if #(
    parameter int unsigned DEPTH = 16
);
    logic                   push;
    logic [15:0]            push_data;
    logic                   clear;
    logic                   run;
    logic                   fetch_en;
    logic [15:0]            instr_out;
    logic                   instr_valid;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   hlt_seen;
    logic [15:0]            issued;

    modport master (
        output push, push_data, clear, run, fetch_en,
        input  instr_out, instr_valid, full, count, hlt_seen, issued
    );

    modport slave (
        input  push, push_data, clear, run, fetch_en,
        output instr_out, instr_valid, full, count, hlt_seen, issued
    );
endinterface

// File: rtl/instr_stream_src.sv
// Buffers host-written instruction words in a circular FIFO and issues them
// to a CPU one per fetch cycle, halting after an opcode-F word has gone out.
module instr_stream_src #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input logic               clk,
    input logic               rst_n,
    instr_stream_src_if.slave bus
);
    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [AW:0]    FullCnt = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e         state_q, state_d;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [15:0]    instr_q, instr_d;
    logic [15:0]    issued_q, issued_d;
    logic           valid_q, valid_d;
    logic           hlt_q, hlt_d;
    logic           do_push, do_pop;
    logic           full;
    logic [15:0]    head;

    assign full = (count_q == FullCnt);
    assign head = mem[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        hlt_d    = hlt_q;
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        do_push  = 1'b0;
        do_pop   = 1'b0;

        if (bus.clear) begin
            state_d  = StIdle;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            issued_d = '0;
            hlt_d    = 1'b0;
        end else begin
            do_pop  = (state_q == StRun) && bus.run && bus.fetch_en && (count_q != '0);
            // Fullness is judged before any same-edge pop frees a slot.
            do_push = bus.push && !full;

            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                instr_d  = head;
                valid_d  = 1'b1;
                issued_d = issued_q + 16'd1;
                if (head[15:12] == 4'hF) hlt_d = 1'b1;
            end
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);

            if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
            else if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);

            case (state_q)
                StIdle: if (bus.run) state_d = StRun;
                StRun: begin
                    if (!bus.run)                             state_d = StIdle;
                    else if (do_pop && head[15:12] == 4'hF)   state_d = StHalt;
                end
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
            hlt_q    <= 1'b0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            hlt_q    <= hlt_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    // Storage needs no reset: emptiness is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= bus.push_data;
    end

    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.full        = full;
    assign bus.count       = count_q;
    assign bus.hlt_seen    = hlt_q;
    assign bus.issued      = issued_q;
endmodule

// File: tb/tb_instr_stream_src.sv
// Scoreboard bench for instr_stream_src: a queue-based reference model predicts
// every issued word; a monitor checks each cycle's outputs against it.
module tb_instr_stream_src;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] NOP   = 16'h00EE;
    localparam int MIdle = 0, MRun = 1, MHalt = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_stream_src_if #(.DEPTH(DEPTH)) bus();

    instr_stream_src #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mdl_q[$];
    logic [15:0] exp_q[$];
    int          mode       = MIdle;
    logic [15:0] mdl_issued = '0;
    logic        mdl_hlt    = 1'b0;
    logic [15:0] mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        mode       = MIdle;
        mdl_issued = '0;
        mdl_hlt    = 1'b0;
    endtask

    // Apply inputs for the coming rising edge and advance the model across it.
    task automatic step(input logic p, input logic [15:0] d, input logic c,
                        input logic r, input logic f);
        logic        pop, was_full, halt;
        logic [15:0] w;
        @(negedge clk);
        bus.push = p; bus.push_data = d; bus.clear = c; bus.run = r; bus.fetch_en = f;
        if (c) begin
            mdl_q.delete();
            mode       = MIdle;
            mdl_issued = '0;
            mdl_hlt    = 1'b0;
        end else begin
            pop      = (mode == MRun) && r && f && (mdl_q.size() > 0);
            was_full = (mdl_q.size() == DEPTH);
            halt     = 1'b0;
            if (pop) begin
                w = mdl_q.pop_front();
                exp_q.push_back(w);
                mdl_issued++;
                if (w[15:12] == 4'hF) begin
                    mdl_hlt = 1'b1;
                    halt    = 1'b1;
                end
            end
            if (p && !was_full) mdl_q.push_back(d);
            case (mode)
                MIdle:   if (r) mode = MRun;
                MRun:    if (!r) mode = MIdle; else if (halt) mode = MHalt;
                default: ;
            endcase
        end
    endtask

    task automatic pushw(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runc(input int n, input logic f);
        repeat (n) step(1'b0, 16'h0, 1'b0, 1'b1, f);
    endtask

    task automatic clr();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        bus.push = 0; bus.push_data = 0; bus.clear = 0; bus.run = 0; bus.fetch_en = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid",  {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_out",    {16'b0, bus.instr_out}, {16'b0, NOP});
        chk("rst_count",  {27'b0, bus.count}, 32'd0);
        chk("rst_full",   {31'b0, bus.full}, 32'd0);
        chk("rst_hlt",    {31'b0, bus.hlt_seen}, 32'd0);
        chk("rst_issued", {16'b0, bus.issued}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops an expected word whenever the DUT claims an issue.
    always @(posedge clk) begin
        #1;
        if (bus.instr_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_issue", {31'b0, bus.instr_valid}, 32'd0);
            end else begin
                mon_w = exp_q.pop_front();
                chk("instr_out", {16'b0, bus.instr_out}, {16'b0, mon_w});
            end
        end else begin
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                chk("missing_issue", {31'b0, bus.instr_valid}, 32'd1);
            end
            chk("nop_out", {16'b0, bus.instr_out}, {16'b0, NOP});
        end
        chk("count",    {27'b0, bus.count}, mdl_q.size());
        chk("full",     {31'b0, bus.full}, {31'b0, mdl_q.size() == DEPTH});
        chk("hlt_seen", {31'b0, bus.hlt_seen}, {31'b0, mdl_hlt});
        chk("issued",   {16'b0, bus.issued}, {16'b0, mdl_issued});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        int          guard;
        bus.push = 0; bus.push_data = 0; bus.clear = 0; bus.run = 0; bus.fetch_en = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic issue ending in HLT, then behaviour while halted and after clear.
        pushw(16'hB102); pushw(16'hA100); pushw(16'hF000);
        runc(6, 1'b1);
        chk("hlt_issued3", {16'b0, bus.issued}, 32'd3);
        chk("hlt_flag",    {31'b0, bus.hlt_seen}, 32'd1);
        pushw(16'h0462);
        runc(1, 1'b1); runc(1, 1'b0); runc(1, 1'b1);
        chk("halt_held_count", {27'b0, bus.count}, 32'd1);
        clr();
        runc(3, 1'b1);
        chk("post_clear_issued", {16'b0, bus.issued}, 32'd0);

        // Overfill: 17th word must be dropped.
        clr();
        for (int i = 1; i <= 16; i++) pushw(16'h1000 + 16'(i));
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("fill_full",  {31'b0, bus.full}, 32'd1);
        chk("fill_count", {27'b0, bus.count}, 32'd16);
        pushw(16'h1011);
        chk("drop_count", {27'b0, bus.count}, 32'd16);
        runc(20, 1'b1);
        chk("fill_issued", {16'b0, bus.issued}, 32'd16);

        // fetch_en gaps.
        clr();
        pushw(16'hA001); pushw(16'hA002);
        runc(1, 1'b0); runc(1, 1'b1); runc(1, 1'b0); runc(1, 1'b1); runc(1, 1'b0);

        // Asynchronous reset mid-stream discards buffered words.
        clr();
        pushw(16'h2001); pushw(16'h2002); pushw(16'h2003);
        runc(1, 1'b0); runc(1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        mid_reset();
        pushw(16'h1462);
        runc(3, 1'b1);
        chk("post_rst_issued", {16'b0, bus.issued}, 32'd1);

        // 40 words streamed through with concurrent push and pop.
        clr();
        runc(1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b1, 1'b1);
        guard = 0;
        while (mdl_q.size() > 0 && guard < 50) begin
            runc(1, 1'b1);
            guard++;
        end
        runc(1, 1'b1);
        chk("stream_issued", {16'b0, bus.issued}, 32'd40);

        // Randomized traffic.
        clr();
        for (int i = 0; i < 1500; i++) begin
            d = 16'($urandom);
            if (d[15:12] == 4'hF && ($urandom % 40) != 0) d[15:12] = 4'h7;
            step(1'($urandom % 2), d,
                 (mode == MHalt) ? (($urandom % 8) == 0) : (($urandom % 100) == 0),
                 ($urandom % 8) != 0, ($urandom % 3) != 0);
        end
        repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
